// File: rtl/alu4_regfile_wb_if.sv
// Write-back bundle from the 4-bit ALU into the register-file stage.
// The producer holds the bundle until in_valid and in_ready meet at a clock edge.
interface alu4_regfile_wb_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AW    = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [AW-1:0]    in_dest;
  logic             in_reg_we;
  logic             in_c;
  logic             in_rc;
  logic             in_v;
  logic [3:0]       in_flag_we;

  modport master (
    output in_valid, in_result, in_dest, in_reg_we, in_c, in_rc, in_v, in_flag_we,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_result, in_dest, in_reg_we, in_c, in_rc, in_v, in_flag_we,
    output in_ready
  );
endinterface

// File: rtl/alu4_regfile_wb.sv
// ALU write-back stage: register file, flag register, retire counter and a
// two-state clear sweep. Reads are unbypassed to avoid a loop through the ALU.
module alu4_regfile_wb #(
  parameter int unsigned     WIDTH     = 4,
  parameter int unsigned     REGS      = 4,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0,
  parameter int unsigned     CNT_W     = 8,
  localparam int unsigned    AW        = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  alu4_regfile_wb_if.slave      wb,
  input  logic [AW-1:0]         rd_a_addr,
  input  logic [AW-1:0]         rd_b_addr,
  output logic [WIDTH-1:0]      rd_a_data,
  output logic [WIDTH-1:0]      rd_b_data,
  output logic                  flag_c,
  output logic                  flag_rc,
  output logic                  flag_v,
  output logic                  flag_z,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    clr_idx;
  logic [WIDTH-1:0] regs [REGS];

  assign wb.in_ready = (state == IDLE);
  assign busy        = (state == CLEAR);
  assign rd_a_data   = regs[rd_a_addr];
  assign rd_b_data   = regs[rd_b_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REGS; i++) regs[i] <= '0;
      flag_c     <= 1'b0;
      flag_rc    <= 1'b0;
      flag_v     <= 1'b0;
      flag_z     <= 1'b0;
      state      <= IDLE;
      clr_idx    <= '0;
      retire_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A bundle accepted on the same edge as clr_req still commits;
          // the sweep then overwrites its register.
          if (wb.in_valid) begin
            if (wb.in_reg_we)     regs[wb.in_dest] <= wb.in_result;
            if (wb.in_flag_we[0]) flag_c  <= wb.in_c;
            if (wb.in_flag_we[1]) flag_rc <= wb.in_rc;
            if (wb.in_flag_we[2]) flag_v  <= wb.in_v;
            if (wb.in_flag_we[3]) flag_z  <= (wb.in_result == '0);
            retire_cnt <= retire_cnt + CNT_W'(1);
          end
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          regs[clr_idx] <= CLR_VALUE;
          clr_idx       <= clr_idx + AW'(1);
          if (clr_idx == AW'(REGS - 1)) begin
            flag_c  <= 1'b0;
            flag_rc <= 1'b0;
            flag_v  <= 1'b0;
            flag_z  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_regfile_wb.sv
// Bench for alu4_regfile_wb: directed vector table, hand-written sweep/reset
// sequences, and random traffic against an abstract register-file model.
module tb_alu4_regfile_wb;

  logic       clk;
  logic       rst;
  logic [1:0] rd_a_addr, rd_b_addr;
  logic [3:0] rd_a_data, rd_b_data;
  logic       flag_c, flag_rc, flag_v, flag_z;
  logic       clr_req;
  logic       busy;
  logic [7:0] retire_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu4_regfile_wb_if #(.WIDTH(4), .AW(2)) bus ();

  alu4_regfile_wb #(.WIDTH(4), .REGS(4), .CLR_VALUE(4'h0), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (bus),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .flag_c    (flag_c),
    .flag_rc   (flag_rc),
    .flag_v    (flag_v),
    .flag_z    (flag_z),
    .clr_req   (clr_req),
    .busy      (busy),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of register contents plus a sweep countdown.
  logic [3:0]  m_regs [4];
  logic        m_c, m_rc, m_v, m_z;
  logic [7:0]  m_cnt;
  int unsigned m_left;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    {m_c, m_rc, m_v, m_z} = 4'b0;
    m_cnt  = 8'd0;
    m_left = 0;
  endtask

  // Applies what the coming clock edge must do, given current inputs.
  task automatic model_edge();
    if (m_left > 0) begin
      m_regs[4 - m_left] = 4'h0;
      m_left--;
      if (m_left == 0) {m_c, m_rc, m_v, m_z} = 4'b0;
    end else begin
      if (bus.in_valid) begin
        if (bus.in_reg_we) m_regs[bus.in_dest] = bus.in_result;
        if (bus.in_flag_we[0]) m_c  = bus.in_c;
        if (bus.in_flag_we[1]) m_rc = bus.in_rc;
        if (bus.in_flag_we[2]) m_v  = bus.in_v;
        if (bus.in_flag_we[3]) m_z  = (bus.in_result == 4'h0);
        m_cnt = m_cnt + 8'd1;
      end
      if (clr_req) m_left = 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {flag_z, flag_v, flag_rc, flag_c};
  endfunction

  // Full compare of visible state against the model; takes 4 time units.
  task automatic check_all(input string tag);
    chk({tag, "_flags"}, 32'(dut_flags()), 32'({m_z, m_v, m_rc, m_c}));
    chk({tag, "_cnt"},   32'(retire_cnt), 32'(m_cnt));
    chk({tag, "_busy"},  32'(busy), 32'(m_left > 0));
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'(m_left == 0));
    for (int i = 0; i < 4; i++) begin
      rd_a_addr = 2'(i);
      rd_b_addr = 2'(3 - i);
      #1;
      chk({tag, "_rda"}, 32'(rd_a_data), 32'(m_regs[i]));
      chk({tag, "_rdb"}, 32'(rd_b_data), 32'(m_regs[3 - i]));
    end
  endtask

  task automatic drive(input logic [1:0] dest, input logic [3:0] res, input logic we,
                       input logic [3:0] fwe, input logic c, input logic rc, input logic v);
    bus.in_dest    = dest;
    bus.in_result  = res;
    bus.in_reg_we  = we;
    bus.in_flag_we = fwe;
    bus.in_c       = c;
    bus.in_rc      = rc;
    bus.in_v       = v;
  endtask

  typedef struct {
    logic [1:0] dest;
    logic [3:0] result;
    logic       reg_we;
    logic [3:0] flag_we;
    logic       c, rc, v;
    logic [3:0] exp_pre;    // rd_b at dest in the acceptance cycle
    logic [3:0] exp_rd;     // rd_a at dest one cycle later
    logic [3:0] exp_flags;  // {z, v, rc, c}
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [6];

  logic [7:0] saved_cnt;
  logic       saw_wrap;

  initial begin
    vecs[0] = '{2'd2, 4'hA, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 4'h0, 4'hA, 4'b0101, 8'd1};
    vecs[1] = '{2'd2, 4'h0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 4'b1101, 8'd2};
    vecs[2] = '{2'd1, 4'h5, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 4'b1101, 8'd3};
    vecs[3] = '{2'd3, 4'hF, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'b0010, 8'd4};
    vecs[4] = '{2'd0, 4'h0, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'b1011, 8'd5};
    vecs[5] = '{2'd3, 4'h7, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 4'b1111, 8'd6};

    rst = 1'b1;
    clr_req = 1'b0;
    bus.in_valid = 1'b0;
    drive(2'd0, 4'h0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    rd_a_addr = 2'd0;
    rd_b_addr = 2'd0;
    model_reset();

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_cnt",   32'(retire_cnt), 32'd0);
    chk("rst_flags", 32'(dut_flags()), 32'd0);
    check_all("rst");
    rst = 1'b0;
    step();

    // Directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].dest, vecs[i].result, vecs[i].reg_we, vecs[i].flag_we,
            vecs[i].c, vecs[i].rc, vecs[i].v);
      bus.in_valid = 1'b1;
      rd_b_addr = vecs[i].dest;
      #1;
      chk("vec_nobypass", 32'(rd_b_data), 32'(vecs[i].exp_pre));
      model_edge();
      step();
      bus.in_valid = 1'b0;
      rd_a_addr = vecs[i].dest;
      #1;
      chk("vec_rd",    32'(rd_a_data), 32'(vecs[i].exp_rd));
      chk("vec_flags", 32'(dut_flags()), 32'(vecs[i].exp_flags));
      chk("vec_cnt",   32'(retire_cnt), 32'(vecs[i].exp_cnt));
    end

    // Clear sweep with a bundle accepted on the request edge
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 4'(i + 1), 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
      bus.in_valid = 1'b1;
      model_edge();
      step();
    end
    bus.in_valid = 1'b0;
    check_all("preload");
    drive(2'd0, 4'h9, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    clr_req = 1'b1;
    saved_cnt = retire_cnt + 8'd1;
    model_edge();
    step();
    clr_req = 1'b0;
    drive(2'd1, 4'hE, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt_counted", 32'(retire_cnt), 32'(saved_cnt));
    chk("clr_busy0",  32'(busy), 32'd1);
    chk("clr_ready0", 32'(bus.in_ready), 32'd0);
    for (int k = 1; k < 4; k++) begin
      model_edge();
      step();
      chk("clr_busy",  32'(busy), 32'd1);
      chk("clr_ready", 32'(bus.in_ready), 32'd0);
    end
    model_edge();
    step();
    bus.in_valid = 1'b0;
    chk("clr_end_busy",  32'(busy), 32'd0);
    chk("clr_end_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_end_cnt",   32'(retire_cnt), 32'(saved_cnt));
    chk("clr_end_flags", 32'(dut_flags()), 32'd0);
    check_all("clr_end");

    // Reset on the second sweep cycle
    drive(2'd2, 4'h7, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    model_edge();
    step();
    bus.in_valid = 1'b0;
    clr_req = 1'b1;
    model_edge();
    step();
    clr_req = 1'b0;
    model_edge();
    step();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    chk("midrst_busy",  32'(busy), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    check_all("midrst");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      clr_req = ($urandom_range(0, 15) == 0);
      model_edge();
      step();
      rd_a_addr = 2'($urandom_range(0, 3));
      rd_b_addr = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_rda",   32'(rd_a_data), 32'(m_regs[rd_a_addr]));
      chk("rnd_rdb",   32'(rd_b_data), 32'(m_regs[rd_b_addr]));
      chk("rnd_flags", 32'(dut_flags()), 32'({m_z, m_v, m_rc, m_c}));
      chk("rnd_cnt",   32'(retire_cnt), 32'(m_cnt));
      chk("rnd_busy",  32'(busy), 32'(m_left > 0));
    end
    bus.in_valid = 1'b0;
    clr_req = 1'b0;
    while (m_left > 0) begin
      model_edge();
      step();
    end
    check_all("rnd_end");

    // Counter wrap with no-effect bundles
    saved_cnt = retire_cnt;
    saw_wrap = 1'b0;
    for (int n = 0; n < 256; n++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0, 4'b0000,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.in_valid = 1'b1;
      model_edge();
      step();
      chk("wrap_cnt", 32'(retire_cnt), 32'(m_cnt));
      if (retire_cnt == 8'd0) saw_wrap = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("wrap_seen",  32'(saw_wrap), 32'd1);
    chk("wrap_final", 32'(retire_cnt), 32'(saved_cnt));
    check_all("wrap_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu4_regfile_wb.md
Name: alu4_regfile_wb

Overview:
- Write-back and operand-storage stage directly downstream of the 4-bit ALU.
- Captures each ALU result and its flags into a small register file and a flag register.
- Registered operands and carry flags are fed back to the ALU's A/B inputs and carry-ins on the next cycle.
- Provides a valid/ready write handshake, a multi-cycle clear sweep sequenced by a two-state FSM, and a retire counter.

Parameters:
- WIDTH, 4, data width of each register and of the ALU result.
- REGS, 4, number of registers; a power of two, at least 2.
- CLR_VALUE, 0, value written to every register during a clear sweep.
- CNT_W, 8, width of the retire counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  ALU result bundle is valid this cycle.
- in_ready  out  1  stage can accept a bundle.
- in_result  in  WIDTH  ALU result.
- in_dest  in  log2(REGS)  destination register index.
- in_reg_we  in  1  write in_result to in_dest.
- in_c  in  1  ALU math carry-out.
- in_rc  in  1  ALU rotate carry-out.
- in_v  in  1  ALU overflow.
- in_flag_we  in  4  per-flag update enables: [0]=C, [1]=RC, [2]=V, [3]=Z.
- rd_a_addr  in  log2(REGS)  read port A index.
- rd_b_addr  in  log2(REGS)  read port B index.
- rd_a_data  out  WIDTH  register contents at rd_a_addr; combinational read of committed state.
- rd_b_data  out  WIDTH  register contents at rd_b_addr; combinational read of committed state.
- flag_c  out  1  registered math carry; drives the ALU math carry-in.
- flag_rc  out  1  registered rotate carry; drives the ALU rotate carry-in.
- flag_v  out  1  registered overflow.
- flag_z  out  1  registered zero.
- clr_req  in  1  request a clear sweep (single-cycle pulse or level).
- busy  out  1  clear sweep in progress.
- retire_cnt  out  CNT_W  count of accepted bundles.

Behaviour:
- Reset (rst=1 at an edge):
  - All registers become 0 (not CLR_VALUE); all flags 0; FSM goes to IDLE; clear index 0; retire_cnt 0.
  - in_ready=1 and busy=0 from the first cycle after reset.
  - Reset has priority over every other input, including mid-sweep.
- Handshake:
  - in_ready = (state==IDLE); it is purely a function of state, with no combinational dependence on in_valid or clr_req.
  - A bundle is accepted when in_valid and in_ready are both 1 at a rising edge.
  - Bundles presented while in_ready=0 are ignored; the producer must hold them.
- Accepted bundle, all updates at that edge:
  - If in_reg_we: reg[in_dest] <= in_result.
  - Each flag with its in_flag_we bit set loads its value; flag_z loads (in_result==0).
  - Flags with a clear enable bit hold, independent of in_reg_we.
  - retire_cnt increments, wrapping modulo 2^CNT_W (all-ones -> 0). A bundle with in_reg_we=0 and in_flag_we=0 still counts.
- Read ports:
  - No write-to-read bypass; a write becomes visible on rd_*_data the cycle after acceptance.
  - This is mandatory: a bypass would create a combinational loop through the ALU.
  - Both ports may address the same register.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1 at an edge; clear index <= 0. A bundle accepted at that same edge is still written and counted, then overwritten by the sweep.
  - In CLEAR, each cycle: reg[index] <= CLR_VALUE, index++. After the write of index REGS-1, all four flags clear to 0 and the FSM returns to IDLE.
  - The sweep lasts exactly REGS cycles with busy=1 and in_ready=0; the next IDLE cycle has in_ready=1.
  - clr_req asserted during CLEAR is ignored; a clr_req still high on the first IDLE cycle starts a new sweep.
  - retire_cnt is not affected by a clear.
- Reset during CLEAR aborts the sweep: registers 0, state IDLE.
- Out-of-range addresses are impossible since REGS is a power of two.

Test Plan:
- Reset check: hold rst 2 cycles -> all rd_*_data=0, all flags 0, in_ready=1, busy=0, retire_cnt=0.
- Write and read: accept {dest=2, result=0xA, reg_we=1, flag_we=4'b0111, c=1, rc=0, v=1} -> next cycle rd_a_addr=2 reads 0xA; flag_c=1, flag_rc=0, flag_v=1, flag_z=0 (Z held); retire_cnt=1. Then accept result=0x0 with flag_we=4'b1000 -> flag_z=1, other flags unchanged.
- No-bypass: in the acceptance cycle of {dest=1, result=0x5}, rd_b_addr=1 -> still shows the old value 0x0; shows 0x5 one cycle later.
- Clear sweep: preload regs with 0x1..0x4, set flags, pulse clr_req together with a valid bundle -> bundle counted; busy=1 and in_ready=0 for exactly 4 cycles; in_valid held high is not accepted; afterwards all regs read CLR_VALUE, flags 0, retire_cnt unchanged.
- Reset mid-clear: assert rst on the 2nd sweep cycle -> next cycle busy=0, in_ready=1, all regs 0.
- Counter wrap: accept 256 bundles with reg_we=0, flag_we=0 -> retire_cnt passes 255 to 0; registers and flags unchanged.
